ibuff_write_stager: RTL and testbench

//  Write-side producer for the instruction buffer. Sits between Decode and the IB write ports.

---
 rtl/ibuff_write_stager.sv | 140 ++++++++++++++
 tb/tb_ibuff_write_stager.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ibuff_write_stager.sv
// Purpose : two-entry skid stager between Decode and the instruction-buffer write ports.
//           A head bundle leaves only in a cycle where the IB actually accepts it.
// Latency : a bundle pushed in cycle N is presented on the outputs in cycle N+1 (no bypass).
// Backpressure: inReady_o comes from registered occupancy only; pops are held while the IB is full or fetch is stalled.
//
// Ports:
//   clk, reset (async, active-high), flush_i (sync empty)
//   inValid_i / inLaneValid_i / inPkt_i / inReady_o            : decode-side handshake
//   instBufferFull_i / stallFetch_i                            : IB-side hold conditions
//   decodeReady_o / outLaneValid_o / outPkt_o                  : head bundle to the IB
//   fullStallCnt_o / upstreamBlockCnt_o                        : perf counters, only with IBSTAGE_PERF_EN
//
// Build option: define IBSTAGE_PERF_EN to add the two saturating performance counters.

module ibuff_write_stager #(
  parameter int LANES = 8,
  parameter int PKT_W = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   inValid_i,
  input  logic [LANES-1:0]       inLaneValid_i,
  input  logic [LANES*PKT_W-1:0] inPkt_i,
  output logic                   inReady_o,
  input  logic                   instBufferFull_i,
  input  logic                   stallFetch_i,
  output logic                   decodeReady_o,
  output logic [LANES-1:0]       outLaneValid_o,
`ifdef IBSTAGE_PERF_EN
  output logic [31:0]            fullStallCnt_o,
  output logic [31:0]            upstreamBlockCnt_o,
`endif
  output logic [LANES*PKT_W-1:0] outPkt_o
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  logic [1:0]             count_q, count_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [LANES-1:0]       lane_mem_q [DEPTH];
  logic [LANES-1:0]       lane_mem_d [DEPTH];
  logic [LANES*PKT_W-1:0] pkt_mem_q  [DEPTH];
  logic [LANES*PKT_W-1:0] pkt_mem_d  [DEPTH];

  logic push;
  logic pop;

  assign inReady_o     = (count_q != FULL_CNT);
  assign decodeReady_o = (count_q != 2'd0);
  // Lanes are forced to zero when empty so the IB never sees stale valids;
  // the payload is left as-is because it is ignored without decodeReady_o.
  assign outLaneValid_o = decodeReady_o ? lane_mem_q[rd_ptr_q] : '0;
  assign outPkt_o       = pkt_mem_q[rd_ptr_q];

  always_comb begin
    // An all-invalid bundle completes the handshake but is never stored.
    push = inValid_i & inReady_o & (|inLaneValid_i) & ~flush_i;
    // Mirrors the IB's own write-accept condition so every pop is a real write.
    pop  = decodeReady_o & ~instBufferFull_i & ~stallFetch_i & ~flush_i;

    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    lane_mem_d = lane_mem_q;
    pkt_mem_d  = pkt_mem_q;

    if (flush_i) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        lane_mem_d[wr_ptr_q] = inLaneValid_i;
        pkt_mem_d[wr_ptr_q]  = inPkt_i;
        wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    lane_mem_q <= lane_mem_d;
    pkt_mem_q  <= pkt_mem_d;
  end

`ifdef IBSTAGE_PERF_EN
  logic [31:0] full_stall_cnt_q, full_stall_cnt_d;
  logic [31:0] upstream_block_cnt_q, upstream_block_cnt_d;

  // Counters saturate rather than wrap and survive flushes.
  always_comb begin
    full_stall_cnt_d     = full_stall_cnt_q;
    upstream_block_cnt_d = upstream_block_cnt_q;
    if (decodeReady_o && (instBufferFull_i || stallFetch_i) && (full_stall_cnt_q != 32'hFFFF_FFFF))
      full_stall_cnt_d = full_stall_cnt_q + 32'd1;
    if (inValid_i && !inReady_o && (upstream_block_cnt_q != 32'hFFFF_FFFF))
      upstream_block_cnt_d = upstream_block_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_stall_cnt_q     <= 32'd0;
      upstream_block_cnt_q <= 32'd0;
    end else begin
      full_stall_cnt_q     <= full_stall_cnt_d;
      upstream_block_cnt_q <= upstream_block_cnt_d;
    end
  end

  assign fullStallCnt_o     = full_stall_cnt_q;
  assign upstreamBlockCnt_o = upstream_block_cnt_q;
`endif

`ifndef SYNTHESIS
  a_no_push_when_full : assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == FULL_CNT)));
  a_no_pop_when_empty : assert property (@(posedge clk) disable iff (reset)
    !(pop && (count_q == 2'd0)));
`endif

endmodule

// File: tb/tb_ibuff_write_stager.sv
module tb_ibuff_write_stager;

  localparam int LANES = 8;
  localparam int PKT_W = 64;
  localparam int W     = LANES * PKT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush_i = 1'b0;
  logic             inValid_i = 1'b0;
  logic [LANES-1:0] inLaneValid_i = '0;
  logic [W-1:0]     inPkt_i = '0;
  logic             inReady_o;
  logic             instBufferFull_i = 1'b0;
  logic             stallFetch_i = 1'b0;
  logic             decodeReady_o;
  logic [LANES-1:0] outLaneValid_o;
  logic [W-1:0]     outPkt_o;
`ifdef IBSTAGE_PERF_EN
  logic [31:0]      fullStallCnt_o;
  logic [31:0]      upstreamBlockCnt_o;
`endif

  ibuff_write_stager #(.LANES(LANES), .PKT_W(PKT_W), .DEPTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush_i          (flush_i),
    .inValid_i        (inValid_i),
    .inLaneValid_i    (inLaneValid_i),
    .inPkt_i          (inPkt_i),
    .inReady_o        (inReady_o),
    .instBufferFull_i (instBufferFull_i),
    .stallFetch_i     (stallFetch_i),
    .decodeReady_o    (decodeReady_o),
    .outLaneValid_o   (outLaneValid_o),
`ifdef IBSTAGE_PERF_EN
    .fullStallCnt_o     (fullStallCnt_o),
    .upstreamBlockCnt_o (upstreamBlockCnt_o),
`endif
    .outPkt_o         (outPkt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] lv;
    logic [W-1:0]     pk;
  } ent_t;

  ent_t sb[$];          // expected stager contents, head first
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_emit  = 0;    // bundles popped by the IB

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_pkt();
    logic [W-1:0] p;
    for (int i = 0; i < W / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // Compare outputs against the scoreboard, then advance the model and the DUT one cycle.
  // Called just after a falling edge; inputs are applied here and held across the rising edge.
  task automatic step(input logic v, input logic [LANES-1:0] lv, input logic [W-1:0] pk,
                      input logic full, input logic stall, input logic flush, input string tag);
    logic m_push, m_pop;
    ent_t e;
    inValid_i = v; inLaneValid_i = lv; inPkt_i = pk;
    instBufferFull_i = full; stallFetch_i = stall; flush_i = flush;
    #1;
    check({tag, ".inReady"}, W'(inReady_o), W'(sb.size() != 2));
    check({tag, ".decodeReady"}, W'(decodeReady_o), W'(sb.size() != 0));
    if (sb.size() != 0) begin
      check({tag, ".lanes"}, W'(outLaneValid_o), W'(sb[0].lv));
      check({tag, ".pkt"}, outPkt_o, sb[0].pk);
    end else begin
      check({tag, ".lanes_empty"}, W'(outLaneValid_o), '0);
    end
    m_push = v && (sb.size() != 2) && (|lv) && !flush;
    m_pop  = (sb.size() != 0) && !full && !stall && !flush;
    if (flush) sb.delete();
    else begin
      if (m_pop) begin void'(sb.pop_front()); n_emit++; end
      if (m_push) begin e.lv = lv; e.pk = pk; sb.push_back(e); end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic [W-1:0] pa, pb, pc, px;
    int e0;

    // Reset state
    inValid_i = 1'b0; flush_i = 1'b0; instBufferFull_i = 1'b0; stallFetch_i = 1'b0;
    do_reset();
    check("rst.inReady", W'(inReady_o), W'(1));
    check("rst.decodeReady", W'(decodeReady_o), W'(0));
    check("rst.lanes", W'(outLaneValid_o), W'(0));

    // 1: single full bundle, visible one cycle later and popped immediately
    pa = rnd_pkt();
    e0 = n_emit;
    step(1'b1, 8'hFF, pa, 1'b0, 1'b0, 1'b0, "t1.push");
    idle("t1.out");
    idle("t1.empty");
    check("t1.emitted", W'(n_emit - e0), W'(1));

    // 2: IB full while A, B, C are offered; C must wait upstream
    pa = rnd_pkt(); pb = rnd_pkt(); pc = rnd_pkt();
    e0 = n_emit;
    step(1'b1, 8'h0F, pa, 1'b1, 1'b0, 1'b0, "t2.A");
    step(1'b1, 8'hF0, pb, 1'b1, 1'b0, 1'b0, "t2.B");
    step(1'b1, 8'h81, pc, 1'b1, 1'b0, 1'b0, "t2.C_blocked");
    check("t2.held", W'(n_emit - e0), W'(0));
    step(1'b1, 8'h81, pc, 1'b0, 1'b0, 1'b0, "t2.popA");
    step(1'b1, 8'h81, pc, 1'b0, 1'b0, 1'b0, "t2.popB_pushC");
    idle("t2.popC");
    idle("t2.empty");
    check("t2.emitted", W'(n_emit - e0), W'(3));

    // 3: continuous stream at one bundle per cycle
    e0 = n_emit;
    for (int i = 0; i < 10; i++)
      step(1'b1, LANES'($urandom_range(1, 255)), rnd_pkt(), 1'b0, 1'b0, 1'b0, "t3.stream");
    idle("t3.drain");
    idle("t3.empty");
    check("t3.emitted", W'(n_emit - e0), W'(10));

    // 4: all-invalid bundle is accepted but never stored
    e0 = n_emit;
    step(1'b1, 8'h00, rnd_pkt(), 1'b0, 1'b0, 1'b0, "t4.zero");
    idle("t4.after");
    check("t4.emitted", W'(n_emit - e0), W'(0));

    // 5a: flush with count=2, head pop-eligible, bundle offered
    step(1'b1, 8'h11, rnd_pkt(), 1'b1, 1'b0, 1'b0, "t5.fill0");
    step(1'b1, 8'h22, rnd_pkt(), 1'b1, 1'b0, 1'b0, "t5.fill1");
    px = rnd_pkt();
    e0 = n_emit;
    step(1'b1, 8'h33, px, 1'b0, 1'b0, 1'b1, "t5.flush2");
    idle("t5.after2");
    // 5b: flush with count=1 where push and pop would both be legal
    step(1'b1, 8'h44, rnd_pkt(), 1'b0, 1'b0, 1'b0, "t5.fill");
    step(1'b1, 8'h55, px, 1'b0, 1'b0, 1'b1, "t5.flush1");
    idle("t5.after1");
    check("t5.emitted", W'(n_emit - e0), W'(0));

    // 6: fetch stall holds the head, then asynchronous reset mid-stall
    do_reset();
    pa = rnd_pkt();
    step(1'b1, 8'hA5, pa, 1'b0, 1'b0, 1'b0, "t6.push");
    e0 = n_emit;
    for (int i = 0; i < 5; i++)
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "t6.stall");
    check("t6.held", W'(n_emit - e0), W'(0));
`ifdef IBSTAGE_PERF_EN
    check("t6.fullStallCnt", W'(fullStallCnt_o), W'(5));
`endif
    // Reset pulse between clock edges must clear outputs without a clock
    reset = 1'b1;
    #1;
    check("t6.rst.decodeReady", W'(decodeReady_o), W'(0));
    check("t6.rst.inReady", W'(inReady_o), W'(1));
    check("t6.rst.lanes", W'(outLaneValid_o), W'(0));
`ifdef IBSTAGE_PERF_EN
    check("t6.rst.fullStallCnt", W'(fullStallCnt_o), W'(0));
    check("t6.rst.upstreamBlockCnt", W'(upstreamBlockCnt_o), W'(0));
`endif
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    stallFetch_i = 1'b0;
    idle("t6.post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
